// File: rtl/ram4k_arbiter.sv
// Burst-limited round-robin arbiter and command sequencer for ram4k.
// Reads return through an in-order tag pipeline at fixed latency.
module ram4k_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        g0, g1;
  logic        acc;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [7:0]  sel_din;

  logic        ram_we_q;
  logic [11:0] ram_addr_q;
  logic [7:0]  ram_din_q;
  logic [RD_LAT:0] tv_q;
  logic [RD_LAT:0] tp_q;
  logic        rvalid0_q, rvalid1_q;
  logic [7:0]  rdata0_q, rdata1_q;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state_q)
      IDLE: begin
        g0 = req0 & (~req1 | last_q);
        g1 = req1 & (~req0 | ~last_q);
      end
      OWN0: begin
        if (req0 && (!req1 || bcnt_q < MAXB)) g0 = 1'b1;
        else g1 = req1;
      end
      OWN1: begin
        if (req1 && (!req0 || bcnt_q < MAXB)) g1 = 1'b1;
        else g0 = req0;
      end
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
  end

  assign gnt0 = g0 & ~rst;
  assign gnt1 = g1 & ~rst;
  assign acc  = g0 | g1;

  assign sel_we   = g1 ? we1 : we0;
  assign sel_addr = g1 ? addr1 : addr0;
  assign sel_din  = g1 ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    if (g0) begin
      state_d = OWN0;
      if (state_q == OWN0) begin
        if (bcnt_q < MAXB) bcnt_d = bcnt_q + 4'd1;
      end else begin
        bcnt_d = 4'd1;
        if (state_q == OWN1) last_d = 1'b1;
      end
    end else if (g1) begin
      state_d = OWN1;
      if (state_q == OWN1) begin
        if (bcnt_q < MAXB) bcnt_d = bcnt_q + 4'd1;
      end else begin
        bcnt_d = 4'd1;
        if (state_q == OWN0) last_d = 1'b0;
      end
    end else if (state_q == OWN0) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end else if (state_q == OWN1) begin
      state_d = IDLE;
      last_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      bcnt_q     <= 4'd0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 12'd0;
      ram_din_q  <= 8'd0;
      tv_q       <= '0;
      tp_q       <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 8'd0;
      rdata1_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      bcnt_q   <= bcnt_d;
      ram_we_q <= acc & sel_we;
      if (acc) begin
        ram_addr_q <= sel_addr;
        ram_din_q  <= sel_din;
      end
      // tag 0 lines up with the cycle ram_addr is presented
      tv_q[0] <= acc & ~sel_we;
      tp_q[0] <= g1;
      for (int i = 1; i <= RD_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tp_q[i] <= tp_q[i-1];
      end
      rvalid0_q <= tv_q[RD_LAT] & ~tp_q[RD_LAT];
      rvalid1_q <= tv_q[RD_LAT] & tp_q[RD_LAT];
      if (tv_q[RD_LAT] && !tp_q[RD_LAT]) rdata0_q <= ram_dout;
      if (tv_q[RD_LAT] && tp_q[RD_LAT])  rdata1_q <= ram_dout;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = |tv_q;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Scoreboard bench for ram4k_arbiter with a behavioural ram4k model.
// Stimulus pushes expected read returns; a monitor pops and compares.
module tb_ram4k_arbiter;

  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        busy;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [7:0] mem [4096];

  ram4k_arbiter #(
    .RD_LAT(RD_LAT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ram4k model, read-first, RD_LAT = 1
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    exp_t e;
    logic       ap;
    logic [7:0] ad;
    if (!rst) begin
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL gnt_excl: both grants high at cycle %0d", cyc);
      end
    end
    if (rvalid0 || rvalid1) begin
      checks++;
      ap = rvalid1;
      ad = rvalid1 ? rdata1 : rdata0;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexp: port %0d data %02h at cycle %0d, none expected",
                 ap, ad, cyc);
      end else begin
        e = sb.pop_front();
        if ((rvalid0 && rvalid1) || ap != e.port || ad !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL rdata: got port %0d data %02h cycle %0d, expected port %0d data %02h cycle %0d",
                   ap, ad, cyc, e.port, e.data, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL rvalid_missing: port %0d data %02h due cycle %0d, none by %0d",
               e.port, e.data, e.due, cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic port, input logic we,
                       input logic [11:0] a, input logic [7:0] d,
                       input logic [7:0] expd);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (port ? gnt1 : gnt0) begin
        ok = 1'b1;
        if (!we) begin
          e.port = port;
          e.data = expd;
          e.due  = cyc + 2 + RD_LAT;
          sb.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    if (port) req1 = 1'b0;
    else req0 = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: port %0d addr %03h got no grant in 20 cycles, needed one",
               port, a);
    end
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int pat[4];
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;

    // reset state, request held high during reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_rvalid", {rvalid1, rvalid0}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0 = 1'b0;

    // full sweep: no bubbles, 2-cycle read latency
    t0 = cyc;
    for (int i = 0; i < 4096; i++)
      issue(1'b0, 1'b1, 12'(i), 8'(i) ^ 8'hA5, 8'h00);
    for (int i = 0; i < 4096; i++)
      issue(1'b0, 1'b0, 12'(i), 8'h00, 8'(i) ^ 8'hA5);
    check("sweep_cycles", cyc - t0, 8192);
    drain();

    // same-address ordering
    issue(1'b0, 1'b0, 12'h7FF, 8'h00, 8'h5A);
    issue(1'b1, 1'b1, 12'h7FF, 8'h3C, 8'h00);
    issue(1'b0, 1'b0, 12'h7FF, 8'h00, 8'h3C);
    issue(1'b0, 1'b0, 12'h7FF, 8'h00, 8'h3C);
    issue(1'b1, 1'b1, 12'h7FF, 8'hC3, 8'h00);
    issue(1'b1, 1'b0, 12'h7FF, 8'h00, 8'hC3);
    drain();

    // burst limit from a fresh reset: port 0 wins first tie
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    we0 = 1'b1; we1 = 1'b1;
    addr0 = 12'h100; addr1 = 12'h101;
    wdata0 = 8'h11; wdata1 = 8'h22;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) check("first_tie_gnt0", gnt0, 1);
      check($sformatf("burst_gnt0_%0d", k), gnt0, (k % 8) < 4);
      check($sformatf("burst_gnt1_%0d", k), gnt1, (k % 8) >= 4);
      @(posedge clk);
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;

    // idle owner handoff
    req0 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("own0_gnt0", gnt0, 1);
      @(posedge clk);
      #1;
    end
    req0 = 1'b0; req1 = 1'b1;
    @(negedge clk);
    check("handoff_gnt1", gnt1, 1);
    check("handoff_gnt0", gnt0, 0);
    @(posedge clk);
    #1;
    req0 = 1'b1;
    pat = '{1, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("after_handoff_gnt1_%0d", k), gnt1, pat[k]);
      @(posedge clk);
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // reset one cycle after a read accept, with a write in flight
    issue(1'b0, 1'b0, 12'h005, 8'h00, 8'hA0);
    issue(1'b0, 1'b1, 12'h006, 8'h77, 8'h00);
    sb.delete();
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
    #1;
    check("rst_async_ram_we", ram_we, 0);
    check("rst_async_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_rvalid", {rvalid1, rvalid0}, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ram_we", ram_we, 0);
      check("midrst_gnt0", gnt0, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0 = 1'b0;
    issue(1'b0, 1'b0, 12'h005, 8'h00, 8'hA0);
    issue(1'b0, 1'b0, 12'h006, 8'h00, 8'hA3);
    drain();

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram4k_arbiter.md
# ram4k_arbiter

Two-requester arbiter and sequencer for the single-port `ram4k` (4096 x 8) array. It accepts read/write requests from port 0 and port 1 over a req/gnt handshake and grants one per cycle using burst-limited round-robin. It issues the winner's command to the RAM one cycle later and returns read data to the originating port at a fixed latency. It sits between the two RAM clients and the `ram4k` instance and is the only driver of the RAM's `we`/`addr`/`din`.

## Interface
- `RD_LAT`, 1: cycles from the RAM sampling `addr` to valid `dout`; legal range is 1..4.
- `MAX_BURST`, 4: maximum consecutive accepts to one port while the other port is requesting; legal range is 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0`, `req1`  in  1  request from port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  12  word address.
- `wdata0`, `wdata1`  in  8  write data.
- `gnt0`, `gnt1`  out  1  grant. Combinational from `req*` and registered state. Never both high.
- `rvalid0`, `rvalid1`  out  1  one-cycle read-return strobe.
- `rdata0`, `rdata1`  out  8  read data, valid only when the matching `rvalid` is high.
- `ram_we`  out  1  to `ram4k.we`.
- `ram_addr`  out  12  to `ram4k.addr`.
- `ram_din`  out  8  to `ram4k.din`.
- `ram_dout`  in  8  from `ram4k.dout`.
- `busy`  out  1  high while any accepted read is still in flight.

## Operation
- Transfer: port x is accepted at a rising edge where `reqx && gntx`.
- Requester duties:
  - Hold `we`/`addr`/`wdata` stable while `req` is high and `gnt` is low.
  - `req` may drop at any time before it is accepted.
- State machine, registered:
  - States are `IDLE`, `OWN0`, `OWN1`.
  - `last` holds the last-served port and resets to 1, so port 0 wins the first tie.
  - `bcnt` (4 bits) counts consecutive accepts by the owner.
- `IDLE`:
  - Only one req: grant it.
  - Both req: grant the port != `last`.
  - Moves to `OWNx` on accept, with `bcnt`=1.
- `OWNx`, owner requesting:
  - Owner is granted if the other port is idle, or if `bcnt` < `MAX_BURST`.
  - If `bcnt` == `MAX_BURST` and the other port requests, grant the other port. Move to `OWNy` with `bcnt`=1 and `last`=x.
  - If the other port is idle, the owner continues. `bcnt` saturates at `MAX_BURST`.
- `OWNx`, owner not requesting:
  - Grant the other port if it requests, moving to `OWNy` with `bcnt`=1.
  - Otherwise go to `IDLE` and set `last`=x.
- Command issue:
  - On accept, register `ram_we`=`we`, `ram_addr`=`addr`, `ram_din`=`wdata`.
  - Without an accept, `ram_we`=0, while `ram_addr`/`ram_din` hold their values.
- Read return: a tag pipeline of depth 1+`RD_LAT` carries {valid, port} for each accepted read. Writes enter no tag.
- When a tag reaches the output stage, `ram_dout` is registered into `rdata[port]` and `rvalid[port]` pulses for one cycle.
- Ordering: single in-order path.
  - A write accepted before a read to the same address is visible to that read.
  - A read accepted before a write returns the old data.
- `busy` = OR of the tag-pipeline valid bits.

## Timing
- Reset values: state `IDLE`, `last`=1, `bcnt`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `rvalid*`=0, `rdata*`=0, all tags invalid, `busy`=0.
- `gnt*` is 0 while `rst` is high.
- Throughput: one accept per cycle, no bubbles, including when ownership switches.
- Write: accepted at edge k; `ram_we`=1 during (k, k+1]; the RAM writes at edge k+1.
- Read: accepted at edge k; `ram_addr` is driven from k; `rdata`/`rvalid` are registered at edge k+1+`RD_LAT`, high for the cycle after it.
  - Default latency is 2 cycles from accept to `rvalid`.
- Reads accepted back-to-back give back-to-back `rvalid` pulses, in accept order, each to its own port.
- Reset mid-operation: all in-flight reads are discarded, no `rvalid` is emitted, `ram_we` drops to 0 immediately (async), and arbitration restarts from the reset state.

## Test plan
- Write/read sweep:
  - Stimulus: port 0 only. Write `addr`=i, `wdata`=i[7:0]^8'hA5 for i=0..4095, then read all 4096 addresses.
  - Required: `gnt0` high every cycle, 4096 `rvalid0` pulses each with `rdata0`=i[7:0]^8'hA5 exactly 2 cycles after accept, `rvalid1` never high.
- Simultaneous first request:
  - Stimulus: after reset, `req0` and `req1` rise in the same cycle.
  - Required: port 0 is granted first.
- Burst limit:
  - Stimulus: `req0` and `req1` held high continuously, `MAX_BURST`=4.
  - Required: grant sequence 0,0,0,0,1,1,1,1,0,... with no idle cycle between grants.
- Same-address ordering:
  - Stimulus: port 1 writes 8'h3C to 12'h7FF, and port 0 reads 12'h7FF accepted on the next cycle.
  - Required: `rdata0`=8'h3C.
  - Stimulus (reversed): port 0's read is accepted before the write.
  - Required: `rdata0` returns the prior contents.
- Idle owner handoff:
  - Stimulus: port 0 owns and drops `req0` while `req1` is high.
  - Required: `gnt1` in that same cycle, and state `OWN1` with `bcnt`=1.
- Reset mid-read:
  - Stimulus: assert `rst` one cycle after a read is accepted.
  - Required: no `rvalid` pulse, `busy`=0 and `ram_we`=0 while in reset, and after release the first request is served normally.
